// File: rtl/score_keeper.sv
// Match scoring: edge-detects goals and start, keeps two saturating 3-bit scores,
// detects match end and sequences the ball-disabled pause before each serve.
module score_keeper #(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       goal_left,
    input  logic       goal_right,
    output logic [2:0] score_left,
    output logic [2:0] score_right,
    output logic       win_left,
    output logic       win_right,
    output logic       ball_enable,
    output logic       serve,
    output logic       serve_dir
);
    localparam logic [2:0] WIN_VAL    = 3'(WIN_SCORE);
    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SERVE_WAIT, PLAY, OVER} state_t;

    state_t     state_q, state_d;
    logic [2:0] score_left_q, score_left_d, score_right_q, score_right_d;
    logic       win_left_q, win_left_d, win_right_q, win_right_d;
    logic       ball_enable_q, ball_enable_d, serve_q, serve_d, serve_dir_q, serve_dir_d;
    logic [7:0] cnt_q, cnt_d;
    logic       start_q, goal_left_q, goal_right_q;
    logic       start_rise, goal_left_rise, goal_right_rise;
    logic [2:0] score_left_inc, score_right_inc;

    assign start_rise      = start & ~start_q;
    assign goal_left_rise  = goal_left & ~goal_left_q;
    assign goal_right_rise = goal_right & ~goal_right_q;
    assign score_left_inc  = score_left_q + 3'd1;
    assign score_right_inc = score_right_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        win_left_d    = win_left_q;
        win_right_d   = win_right_q;
        ball_enable_d = ball_enable_q;
        serve_d       = 1'b0;
        serve_dir_d   = serve_dir_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = SERVE_WAIT;
                    cnt_d   = '0;
                end
            end
            SERVE_WAIT: begin
                if (frame_tick) begin
                    if (cnt_q == PAUSE_LAST) begin
                        state_d       = PLAY;
                        ball_enable_d = 1'b1;
                        serve_d       = 1'b1;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            PLAY: begin
                // Simultaneous rises cancel: neither side scores.
                if (goal_right_rise && !goal_left_rise) begin
                    score_left_d  = score_left_inc;
                    serve_dir_d   = 1'b1;
                    ball_enable_d = 1'b0;
                    cnt_d         = '0;
                    if (score_left_inc == WIN_VAL) begin
                        state_d    = OVER;
                        win_left_d = 1'b1;
                    end else begin
                        state_d = SERVE_WAIT;
                    end
                end else if (goal_left_rise && !goal_right_rise) begin
                    score_right_d = score_right_inc;
                    serve_dir_d   = 1'b0;
                    ball_enable_d = 1'b0;
                    cnt_d         = '0;
                    if (score_right_inc == WIN_VAL) begin
                        state_d     = OVER;
                        win_right_d = 1'b1;
                    end else begin
                        state_d = SERVE_WAIT;
                    end
                end
            end
            OVER: begin
                if (start_rise) begin
                    state_d       = SERVE_WAIT;
                    score_left_d  = '0;
                    score_right_d = '0;
                    win_left_d    = 1'b0;
                    win_right_d   = 1'b0;
                    serve_dir_d   = 1'b0;
                    cnt_d         = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            score_left_q  <= '0;
            score_right_q <= '0;
            win_left_q    <= 1'b0;
            win_right_q   <= 1'b0;
            ball_enable_q <= 1'b0;
            serve_q       <= 1'b0;
            serve_dir_q   <= 1'b0;
            cnt_q         <= '0;
            start_q       <= 1'b0;
            goal_left_q   <= 1'b0;
            goal_right_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            win_left_q    <= win_left_d;
            win_right_q   <= win_right_d;
            ball_enable_q <= ball_enable_d;
            serve_q       <= serve_d;
            serve_dir_q   <= serve_dir_d;
            cnt_q         <= cnt_d;
            start_q       <= start;
            goal_left_q   <= goal_left;
            goal_right_q  <= goal_right;
        end
    end

    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign win_left    = win_left_q;
    assign win_right   = win_right_q;
    assign ball_enable = ball_enable_q;
    assign serve       = serve_q;
    assign serve_dir   = serve_dir_q;
endmodule

// File: tb/tb_score_keeper.sv
// Scoreboarded bench for score_keeper: default build plus a WIN_SCORE=3 / PAUSE_FRAMES=1 build.
module tb_score_keeper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ft = 1'b0, start = 1'b0, gl = 1'b0, gr = 1'b0;
    logic [2:0] score_left, score_right;
    logic win_left, win_right, ball_enable, serve, serve_dir;

    logic ft2 = 1'b0, start2 = 1'b0, gl2 = 1'b0, gr2 = 1'b0;
    logic [2:0] score_left2, score_right2;
    logic win_left2, win_right2, ball_enable2, serve2, serve_dir2;

    always #5 clk = ~clk;

    score_keeper dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(ft), .start(start),
        .goal_left(gl), .goal_right(gr),
        .score_left(score_left), .score_right(score_right),
        .win_left(win_left), .win_right(win_right),
        .ball_enable(ball_enable), .serve(serve), .serve_dir(serve_dir)
    );

    score_keeper #(.WIN_SCORE(3), .PAUSE_FRAMES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .frame_tick(ft2), .start(start2),
        .goal_left(gl2), .goal_right(gr2),
        .score_left(score_left2), .score_right(score_right2),
        .win_left(win_left2), .win_right(win_right2),
        .ball_enable(ball_enable2), .serve(serve2), .serve_dir(serve_dir2)
    );

    typedef struct {int sl; int sr; int wl; int wr; int dir;} exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_err = 0;
    int exp_sl = 0, exp_sr = 0;
    logic [5:0] prev = '0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Any score change pops the next expected record.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev = {score_left, score_right};
        end else if ({score_left, score_right} != prev) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_change", int'({score_left, score_right}), int'(prev));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_score_left", score_left, e.sl);
                chk("sb_score_right", score_right, e.sr);
                chk("sb_win_left", win_left, e.wl);
                chk("sb_win_right", win_right, e.wr);
                chk("sb_serve_dir", serve_dir, e.dir);
            end
            prev = {score_left, score_right};
        end
    end

    task automatic serve_wait();
        logic early;
        early = 1'b0;
        for (int i = 0; i < 59; i++) begin
            ft = 1'b1; cyc(1); ft = 1'b0;
            early |= serve | ball_enable;
            cyc(1);
            early |= serve | ball_enable;
        end
        chk("pause_no_early_serve", early, 0);
        ft = 1'b1; cyc(1); ft = 1'b0;
        chk("serve_pulse", serve, 1);
        chk("serve_ball_en", ball_enable, 1);
        cyc(1);
        chk("serve_one_cycle", serve, 0);
        chk("play_ball_en", ball_enable, 1);
    endtask

    task automatic goal(input bit right);
        exp_t e;
        if (right) exp_sl++; else exp_sr++;
        e.sl = exp_sl; e.sr = exp_sr;
        e.wl = (exp_sl == 7) ? 1 : 0;
        e.wr = (exp_sr == 7) ? 1 : 0;
        e.dir = right ? 1 : 0;
        sb.push_back(e);
        if (right) gr = 1'b1; else gl = 1'b1;
        cyc(1);
        gr = 1'b0; gl = 1'b0;
        cyc(1);
        chk("goal_ball_off", ball_enable, 0);
    endtask

    initial begin
        exp_t e;
        cyc(3);
        chk("rst_score_left", score_left, 0);
        chk("rst_score_right", score_right, 0);
        chk("rst_wins", {win_left, win_right}, 0);
        chk("rst_ball_serve", {ball_enable, serve, serve_dir}, 0);
        rst_n = 1'b1;
        cyc(2);
        ft = 1'b1; cyc(1); ft = 1'b0; cyc(1);
        chk("idle_tick_ignored", {ball_enable, serve}, 0);

        // Start held high through the whole pause counts once.
        start = 1'b1; cyc(1);
        chk("sw_ball_off", ball_enable, 0);
        serve_wait();
        start = 1'b0;
        chk("first_serve_scores", {score_left, score_right}, 0);

        exp_sl = 1;
        e = '{sl: 1, sr: 0, wl: 0, wr: 0, dir: 1};
        sb.push_back(e);
        gr = 1'b1; cyc(500); gr = 1'b0; cyc(1);
        chk("held_goal_score", score_left, 1);
        chk("held_goal_ball_off", ball_enable, 0);
        chk("held_goal_dir", serve_dir, 1);
        serve_wait();

        for (int k = 2; k <= 7; k++) begin
            goal(1'b1);
            if (k < 7) serve_wait();
        end
        chk("win_score", score_left, 7);
        chk("win_left", win_left, 1);
        chk("win_right_clear", win_right, 0);
        for (int i = 0; i < 5; i++) begin
            ft = 1'b1; cyc(1); ft = 1'b0; cyc(1);
        end
        chk("over_ball_off", {ball_enable, serve}, 0);
        gr = 1'b1; cyc(1); gr = 1'b0; cyc(1);
        chk("over_no_increment", score_left, 7);

        exp_sl = 0; exp_sr = 0;
        e = '{sl: 0, sr: 0, wl: 0, wr: 0, dir: 0};
        sb.push_back(e);
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        chk("restart_win_clear", win_left, 0);
        chk("restart_ball_off", ball_enable, 0);
        serve_wait();

        gl = 1'b1; gr = 1'b1; cyc(1); gl = 1'b0; gr = 1'b0; cyc(2);
        chk("simul_ball_on", ball_enable, 1);
        chk("simul_scores", {score_left, score_right}, 0);

        goal(1'b0);
        chk("left_goal_dir", serve_dir, 0);
        serve_wait();
        goal(1'b1); serve_wait();
        goal(1'b1); serve_wait();
        goal(1'b0); serve_wait();
        goal(1'b1);
        chk("pre_reset_scores", {score_left, score_right}, {3'd3, 3'd2});
        for (int i = 0; i < 30; i++) begin
            ft = 1'b1; cyc(1); ft = 1'b0; cyc(1);
        end
        rst_n = 1'b0;
        #1;
        chk("async_rst_scores", {score_left, score_right}, 0);
        chk("async_rst_flags", {win_left, win_right, ball_enable, serve, serve_dir}, 0);
        exp_sl = 0; exp_sr = 0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        for (int i = 0; i < 70; i++) begin
            ft = 1'b1; cyc(1); ft = 1'b0; cyc(1);
        end
        chk("post_rst_needs_start", {ball_enable, serve}, 0);
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        serve_wait();

        // Short-match build: one-frame pause, three points to win.
        start2 = 1'b1; cyc(1); start2 = 1'b0; cyc(1);
        ft2 = 1'b1; cyc(1); ft2 = 1'b0;
        chk("p1_serve", serve2, 1);
        chk("p1_ball_en", ball_enable2, 1);
        cyc(1);
        for (int k = 1; k <= 3; k++) begin
            gl2 = 1'b1; cyc(1); gl2 = 1'b0;
            chk("p1_score_right", score_right2, k);
            cyc(1);
            if (k < 3) begin
                ft2 = 1'b1; cyc(1); ft2 = 1'b0;
                chk("p1_reserve", serve2, 1);
                cyc(1);
            end
        end
        chk("p1_win_right", win_right2, 1);
        chk("p1_win_left", win_left2, 0);
        chk("p1_over_ball_off", ball_enable2, 0);

        cyc(2);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Match-scoring stage; sits directly upstream of the per-player score digit renderers.
- Turns goal events from the ball/collision logic into two saturating 3-bit scores, detects match end, and sequences serve pauses.
- Drives the ball-enable and serve controls back to the ball logic.
- Scores and win flags are registered and stable for whole frames; the renderers consume them without further synchronisation.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..7.
PAUSE_FRAMES, 60, frame_tick pulses of ball-disabled pause before each serve; legal range 1..255.

Ports:
clk  input  1  system/pixel clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle strobe, once per video frame
start  input  1  player start button, already debounced, level
goal_left  input  1  level high while ball is past left edge; point to right player
goal_right  input  1  level high while ball is past right edge; point to left player
score_left  output  3  left player score, 0..WIN_SCORE
score_right  output  3  right player score, 0..WIN_SCORE
win_left  output  1  high while left player has won
win_right  output  1  high while right player has won
ball_enable  output  1  high only in PLAY; ball logic freezes and centres the ball when low
serve  output  1  one-cycle pulse on entry to PLAY
serve_dir  output  1  0 = serve toward left player, 1 = toward right player

Behaviour:
- Reset (async assert, sync release): state IDLE; scores 0; win_left, win_right, ball_enable, serve 0; serve_dir 0; pause counter 0; edge registers 0.
- Edge detect: start, goal_left, goal_right each registered every cycle. Rise = input & ~registered copy. A level held high counts once.
- States:
  - IDLE: on start rise -> SERVE_WAIT; counter cleared.
  - SERVE_WAIT: ball_enable 0. Counter increments on each frame_tick. On frame_tick with counter == PAUSE_FRAMES-1 -> PLAY; that same edge sets serve = 1 for exactly one cycle.
  - PLAY: ball_enable 1. On goal_right rise alone: score_left+1, serve_dir <= 1. On goal_left rise alone: score_right+1, serve_dir <= 0. The score register updates on the same edge the rise is sampled, so it is visible the next cycle. If the new score == WIN_SCORE -> OVER and the matching win flag sets on that edge; otherwise -> SERVE_WAIT with the counter cleared.
  - OVER: ball_enable 0; scores and win flag held. On start rise: scores 0, win flags 0, serve_dir 0, counter cleared -> SERVE_WAIT.
- Goal rises outside PLAY are ignored; the edge registers still track the inputs.
- goal_left and goal_right rising in the same cycle: no score change, remain in PLAY.
- Scores never exceed WIN_SCORE and never wrap. Increments are 3-bit, and OVER blocks further increments.
- win_left and win_right are never both 1.
- frame_tick outside SERVE_WAIT is ignored.
- start rise in SERVE_WAIT or PLAY is ignored.
- Reset asserted mid-pause or mid-play returns to IDLE immediately, asynchronously, with all outputs at reset values.

Test Plan:
- Reset, start rise, 60 frame_ticks -> serve pulses one cycle coincident with ball_enable rising; score_left = score_right = 0.
- PLAY, goal_right held high 500 cycles -> score_left = 1 exactly once; ball_enable 0; serve_dir = 1; next serve after 60 frame_ticks.
- Drive 7 goal_right rises, each after a serve -> score_left = 7, win_left = 1, ball_enable stays 0. An eighth goal_right rise leaves score_left = 7. start rise -> scores 0, win_left 0, SERVE_WAIT.
- PLAY, goal_left and goal_right rise in the same cycle -> scores unchanged, ball_enable stays 1.
- rst_n low mid-SERVE_WAIT (counter = 30), with scores 3/2 -> all outputs 0 immediately; after release, start is needed again and the full 60-tick pause is observed.
- WIN_SCORE = 3, PAUSE_FRAMES = 1 -> serve on the first frame_tick after each point; third goal_left rise gives score_right = 3 and win_right = 1.
